// File: rtl/io_map_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | io_map_pkg : I/O window decode bit, timer register offsets, bit indices   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package io_map_pkg;

  localparam int IO_BASE_BIT = 12;

  localparam logic [3:0] TMR_CTRL  = 4'h0;
  localparam logic [3:0] TMR_COUNT = 4'h4;
  localparam logic [3:0] TMR_CMP   = 4'h8;
  localparam logic [3:0] TMR_STAT  = 4'hC;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_AR        = 1;
  localparam int CTRL_MATCH_IE  = 2;
  localparam int CTRL_OVF_IE    = 3;
  localparam int CTRL_PRESC_LSB = 8;

  localparam int STAT_MATCH = 0;
  localparam int STAT_OVF   = 1;

  typedef enum logic [1:0] {
    SEL_CTRL  = 2'd0,
    SEL_COUNT = 2'd1,
    SEL_CMP   = 2'd2,
    SEL_STAT  = 2'd3
  } tmr_sel_e;

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | timer_prescaler : divides clk by (presc+1), one-cycle tick output         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module timer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               restart,
  output logic               tick
);

  localparam logic [PRESC_W-1:0] c_ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] r_pcnt;

  assign tick = en && (r_pcnt == presc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_pcnt <= '0;
    else if (restart || !en || tick)
      r_pcnt <= '0;
    else
      r_pcnt <= r_pcnt + c_ONE;
  end

endmodule
`default_nettype wire

// File: rtl/io_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | io_timer : memory-mapped prescaled timer with compare, auto-reload, irq   |
// | Optional PWM output when TIMER_PWM_EN is defined.           Rev 1.0       |
// +--------------------------------------------------------------------------+
module io_timer
  import io_map_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        wen,
  input  logic        ren,
  output logic        irq
`ifdef TIMER_PWM_EN
  ,
  output logic        pwm
`endif
);

  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_ONES = '1;

  logic [3:0]         r_flags;
  logic [PRESC_W-1:0] r_presc;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_cmp;
  logic [1:0]         r_stat;
  logic               r_irq;

  tmr_sel_e         w_sel;
  logic             w_wr_ctrl, w_wr_count, w_wr_cmp, w_wr_stat;
  logic             w_tick;
  logic [CNT_W-1:0] w_count_nxt;
  logic [1:0]       w_set, w_clr, w_stat_nxt, w_ie_nxt;
  logic             w_unused;

  assign w_sel      = tmr_sel_e'(addr[3:2]);
  assign w_unused   = ^addr[1:0];
  assign w_wr_ctrl  = wen && (w_sel == SEL_CTRL);
  assign w_wr_count = wen && (w_sel == SEL_COUNT);
  assign w_wr_cmp   = wen && (w_sel == SEL_CMP);
  assign w_wr_stat  = wen && (w_sel == SEL_STAT);

  timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk     (clk),
    .reset   (reset),
    .en      (r_flags[CTRL_EN]),
    .presc   (r_presc),
    .restart (w_wr_ctrl),
    .tick    (w_tick)
  );

  // A CPU store to COUNT swallows any tick in the same cycle, flags included.
  always_comb begin
    w_count_nxt = r_count;
    w_set       = 2'b00;
    if (w_tick && !w_wr_count) begin
      if (r_count == r_cmp) begin
        w_set[STAT_MATCH] = 1'b1;
        if (r_flags[CTRL_AR]) begin
          w_count_nxt = '0;
        end else begin
          w_count_nxt     = r_count + c_CNT_ONE;
          w_set[STAT_OVF] = (r_count == c_CNT_ONES);
        end
      end else if (r_count == c_CNT_ONES) begin
        w_count_nxt     = '0;
        w_set[STAT_OVF] = 1'b1;
      end else begin
        w_count_nxt = r_count + c_CNT_ONE;
      end
    end
    if (w_wr_count)
      w_count_nxt = wdata[CNT_W-1:0];
  end

  assign w_clr      = w_wr_stat ? wdata[1:0] : 2'b00;
  assign w_stat_nxt = (r_stat & ~w_clr) | w_set;
  assign w_ie_nxt   = w_wr_ctrl ? wdata[CTRL_OVF_IE:CTRL_MATCH_IE]
                                : r_flags[CTRL_OVF_IE:CTRL_MATCH_IE];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
      r_presc <= '0;
      r_count <= '0;
      r_cmp   <= '0;
      r_stat  <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_flags <= wdata[3:0];
        r_presc <= wdata[CTRL_PRESC_LSB +: PRESC_W];
      end
      if (w_wr_cmp)
        r_cmp <= wdata[CNT_W-1:0];
      r_count <= w_count_nxt;
      r_stat  <= w_stat_nxt;
      r_irq   <= |(w_stat_nxt & w_ie_nxt);
    end
  end

  assign irq = r_irq;

  always_comb begin
    rdata = 32'h0;
    if (ren) begin
      case (w_sel)
        SEL_CTRL:  rdata = 32'({r_presc, 4'h0, r_flags});
        SEL_COUNT: rdata = 32'(r_count);
        SEL_CMP:   rdata = 32'(r_cmp);
        SEL_STAT:  rdata = {30'h0, r_stat};
        default:   rdata = 32'h0;
      endcase
    end
  end

`ifdef TIMER_PWM_EN
  logic r_pwm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_pwm <= 1'b0;
    else
      r_pwm <= r_flags[CTRL_EN] && (r_count < r_cmp);
  end

  assign pwm = r_pwm;
`endif

endmodule
`default_nettype wire
